uds_seq_ctrl: RTL and testbench



---
 rtl/uds_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_uds_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uds_seq_ctrl.sv
// Job sequencer for the UDS upsample/downsample engine: paces source rows into UDS,
// counts its output beats, and reports completion, watchdog timeouts or protocol errors.
module uds_seq_ctrl #(
    parameter int               A       = 64,
    parameter int               ROW_W   = 12,
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_CYC = 16'd4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROW_W-1:0]     cfg_rows,
    input  logic [1:0]           cfg_scale,
    input  logic [1:0]           cfg_mode,
    input  logic                 src_valid,
    input  logic [A*32-1:0]      src_data,
    output logic                 src_ready,
    output logic                 uds_active,
    output logic [A*32-1:0]      uds_idata,
    output logic                 uds_idata_valid,
    output logic [1:0]           uds_scale_factor,
    output logic [1:0]           uds_function_mode,
    input  logic                 uds_odata_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int CW = ROW_W + 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [1:0] E_CFG  = 2'd1;
    localparam logic [1:0] E_TMO  = 2'd2;
    localparam logic [1:0] E_BEAT = 2'd3;

    logic [2:0]        state_q, state_d;
    logic [ROW_W-1:0]  rows_left_q, rows_left_d;
    logic [1:0]        scale_q, scale_d;
    logic [1:0]        mode_q, mode_d;
    logic [CW-1:0]     exp_q, exp_d;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic [3:0]        grp_q, grp_d;
    logic [3:0]        quota_q, quota_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic [A*32-1:0]   idata_q, idata_d;
    logic              idv_q, idv_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    // Job configuration decode, evaluated on the raw inputs at start time.
    logic [3:0]        cfg_ratio;
    logic [2:0]        cfg_shamt;
    logic [ROW_W-1:0]  cfg_mask;
    logic              cfg_bad;
    logic [CW-1:0]     cfg_exp;

    assign cfg_ratio = 4'd2 << cfg_scale;
    assign cfg_shamt = {1'b0, cfg_scale} + 3'd1;
    assign cfg_mask  = ROW_W'(cfg_ratio) - ROW_W'(1);
    assign cfg_bad   = (cfg_rows == '0) || (cfg_scale == 2'd3) || (cfg_mode > 2'd1) ||
                       ((cfg_mode == 2'd1) && ((cfg_rows & cfg_mask) != '0));
    assign cfg_exp   = (cfg_mode == 2'd0) ? (CW'(cfg_rows) << cfg_shamt)
                                          : CW'(cfg_rows >> cfg_shamt);

    // Per-job ratio and per-group beat quota derived from the latched config.
    logic [3:0]        ratio;
    logic [3:0]        quota_tgt;
    logic [3:0]        quota_next;
    logic [TMO_W-1:0]  wdog_inc;
    logic              hs;
    logic              beat;
    logic              last_row;
    logic              grp_full;

    assign ratio      = 4'd2 << scale_q;
    assign quota_tgt  = (mode_q == 2'd0) ? ratio : 4'd1;
    assign quota_next = quota_q + {3'd0, uds_odata_valid};
    assign wdog_inc   = wdog_q + TMO_W'(1);
    assign hs         = (state_q == S_FEED) && src_valid;
    assign beat       = uds_odata_valid;
    assign last_row   = (rows_left_q == ROW_W'(1));
    assign grp_full   = (mode_q == 2'd0) || ((grp_q + 4'd1) == ratio);

    always_comb begin
        state_d     = state_q;
        rows_left_d = rows_left_q;
        scale_d     = scale_q;
        mode_d      = mode_q;
        exp_d       = exp_q;
        out_cnt_d   = out_cnt_q;
        grp_d       = grp_q;
        quota_d     = quota_q;
        wdog_d      = '0;
        idv_d       = hs;
        idata_d     = hs ? src_data : idata_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = E_BEAT;
                end else if (start) begin
                    scale_d     = cfg_scale;
                    mode_d      = cfg_mode;
                    rows_left_d = cfg_rows;
                    exp_d       = cfg_exp;
                    out_cnt_d   = '0;
                    grp_d       = '0;
                    quota_d     = '0;
                    if (cfg_bad) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = E_CFG;
                    end else begin
                        state_d    = S_ARM;
                        err_d      = 1'b0;
                        err_code_d = 2'd0;
                    end
                end
            end

            // One settling cycle so UDS sees stable scale/mode before data.
            S_ARM: begin
                if (beat) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = E_BEAT;
                end else begin
                    state_d = S_FEED;
                end
            end

            S_FEED: begin
                if (beat) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = E_BEAT;
                end else if (hs) begin
                    rows_left_d = rows_left_q - ROW_W'(1);
                    quota_d     = '0;
                    grp_d       = grp_full ? 4'd0 : (grp_q + 4'd1);
                    if (last_row) begin
                        state_d = S_DRAIN;
                    end else if (grp_full) begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT, S_DRAIN: begin
                if (beat) begin
                    if (out_cnt_q == exp_q) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = E_BEAT;
                    end else begin
                        out_cnt_d = out_cnt_q + CW'(1);
                        quota_d   = quota_next;
                        if (state_q == S_DRAIN) begin
                            if ((out_cnt_q + CW'(1)) == exp_q) begin
                                state_d = S_DONE;
                            end
                        end else if (quota_next == quota_tgt) begin
                            state_d = (rows_left_q == '0) ? S_DRAIN : S_FEED;
                        end
                    end
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == TMO_CYC) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = E_TMO;
                    end
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rows_left_q <= '0;
            scale_q     <= '0;
            mode_q      <= '0;
            exp_q       <= '0;
            out_cnt_q   <= '0;
            grp_q       <= '0;
            quota_q     <= '0;
            wdog_q      <= '0;
            idata_q     <= '0;
            idv_q       <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            rows_left_q <= rows_left_d;
            scale_q     <= scale_d;
            mode_q      <= mode_d;
            exp_q       <= exp_d;
            out_cnt_q   <= out_cnt_d;
            grp_q       <= grp_d;
            quota_q     <= quota_d;
            wdog_q      <= wdog_d;
            idata_q     <= idata_d;
            idv_q       <= idv_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Active/busy decode straight from state so a reset drops them without waiting for a clock.
    logic job_live;
    assign job_live = (state_q == S_ARM) || (state_q == S_FEED) ||
                      (state_q == S_WAIT) || (state_q == S_DRAIN);

    assign busy              = job_live;
    assign uds_active        = job_live;
    assign src_ready         = (state_q == S_FEED);
    assign done              = (state_q == S_DONE);
    assign err               = err_q;
    assign err_code          = err_code_q;
    assign uds_idata         = idata_q;
    assign uds_idata_valid   = idv_q;
    assign uds_scale_factor  = scale_q;
    assign uds_function_mode = mode_q;

endmodule

// File: tb/tb_uds_seq_ctrl.sv
// Randomised bench for uds_seq_ctrl: a count-based job model predicts every output each cycle,
// and a simple UDS model answers each issued row/group with output beats.
module tb_uds_seq_ctrl;
    localparam int               A     = 64;
    localparam int               ROW_W = 12;
    localparam int               TMO_W = 16;
    localparam logic [TMO_W-1:0] TMO   = 16'd16;
    localparam int               DW    = A * 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [ROW_W-1:0] cfg_rows;
    logic [1:0]       cfg_scale;
    logic [1:0]       cfg_mode;
    logic             src_valid;
    logic [DW-1:0]    src_data;
    logic             src_ready;
    logic             uds_active;
    logic [DW-1:0]    uds_idata;
    logic             uds_idata_valid;
    logic [1:0]       uds_scale_factor;
    logic [1:0]       uds_function_mode;
    logic             uds_odata_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    always #5 clk = ~clk;

    uds_seq_ctrl #(.A(A), .ROW_W(ROW_W), .TMO_W(TMO_W), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_scale(cfg_scale),
        .cfg_mode(cfg_mode), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .uds_active(uds_active), .uds_idata(uds_idata), .uds_idata_valid(uds_idata_valid),
        .uds_scale_factor(uds_scale_factor), .uds_function_mode(uds_function_mode),
        .uds_odata_valid(uds_odata_valid), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Job model: counts of rows issued and beats received decide every expected output.
    bit            m_live, m_armed, m_pdone, m_perr, m_err, m_up, m_idv;
    int            m_code, m_rows, m_R, m_exp, m_issued, m_beats, m_idle, m_scale, m_mode;
    logic [DW-1:0] m_idata;

    // UDS model and stimulus controls.
    int due_q[$];
    int nf;
    int stop_after;
    int sent;
    bit src_en;
    bit inject_beat;
    bit inj_feed;

    // Per-job observations of the DUT, compared against hand-derived literals.
    int st_hs, st_hs_pre, st_beats, st_idv, st_done, st_active, st_rdy;
    int done_edge, beat_edge, err_edge, start_edge;
    bit st_err_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_data(input logic [DW-1:0] exp);
        n_checks++;
        if (uds_idata === exp) n_pass++;
        else $display("FAIL uds_idata: got low64 %h expected low64 %h (cycle %0d)",
                      uds_idata[63:0], exp[63:0], cyc);
    endtask

    function automatic int req(input int iss);
        return m_up ? iss * m_R : iss / m_R;
    endfunction

    function automatic bit m_waiting();
        return m_live && m_armed && (m_beats < req(m_issued));
    endfunction

    task automatic model_reset();
        m_live = 0; m_armed = 0; m_pdone = 0; m_perr = 0; m_err = 0; m_up = 0; m_idv = 0;
        m_code = 0; m_rows = 0; m_R = 2; m_exp = 0; m_issued = 0; m_beats = 0; m_idle = 0;
        m_scale = 0; m_mode = 0; m_idata = '0;
    endtask

    task automatic set_err(input int c);
        m_err = 1; m_code = c; m_live = 0; m_armed = 0; m_perr = 1;
    endtask

    task automatic model_step();
        bit b, wt, hs, term;
        b    = uds_odata_valid;
        wt   = m_waiting();
        hs   = m_live && m_armed && !wt && src_valid;
        term = m_pdone || m_perr;
        m_pdone = 0;
        m_perr  = 0;
        m_idv   = hs;
        if (hs) m_idata = src_data;
        if (!m_live) begin
            if (!term) begin
                if (b) set_err(3);
                else if (start) begin
                    m_scale = cfg_scale; m_mode = cfg_mode; m_rows = cfg_rows;
                    m_R = 1 << (cfg_scale + 1);
                    m_up = (cfg_mode == 0);
                    m_exp = m_up ? m_rows * m_R : m_rows / m_R;
                    m_err = 0; m_code = 0;
                    if (m_rows == 0 || cfg_scale == 3 || cfg_mode > 1 || (!m_up && (m_rows % m_R) != 0))
                        set_err(1);
                    else begin
                        m_live = 1; m_armed = 0; m_issued = 0; m_beats = 0; m_idle = 0;
                    end
                end
            end
        end else if (!m_armed) begin
            if (b) set_err(3);
            else m_armed = 1;
        end else if (!wt) begin
            m_idle = 0;
            if (b) set_err(3);
            else if (hs) begin
                m_issued++;
                if (nf < cyc + 3) nf = cyc + 3;
                if (m_up) begin
                    for (int k = 0; k < m_R; k++) begin
                        due_q.push_back(nf);
                        nf += 1 + $urandom_range(0, 1);
                    end
                end else if ((m_issued % m_R) == 0) begin
                    due_q.push_back(nf);
                    nf += 1 + $urandom_range(0, 1);
                end
            end
        end else begin
            if (b) begin
                m_beats++;
                m_idle = 0;
                if (m_beats == m_exp) begin
                    m_live = 0; m_armed = 0; m_pdone = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == int'(TMO)) set_err(2);
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy", busy, m_live);
        chk("uds_active", uds_active, m_live);
        chk("src_ready", src_ready, m_live && m_armed && !m_waiting());
        chk("done", done, m_pdone);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
        chk("uds_idata_valid", uds_idata_valid, m_idv);
        chk("uds_scale_factor", uds_scale_factor, m_scale);
        chk("uds_function_mode", uds_function_mode, m_mode);
        chk_data(m_idata);
    endtask

    task automatic cycle();
        bit b;
        b = 0;
        while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            if (stop_after < 0 || sent < stop_after) b = 1;
        end
        if (inject_beat) b = 1;
        if (inj_feed && m_live && m_armed && !m_waiting() && m_issued >= 1) begin
            b = 1;
            inj_feed = 0;
        end
        uds_odata_valid = b;
        if (src_en) begin
            src_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < A; i++) src_data[i*32 +: 32] = $urandom;
        end else begin
            src_valid = 1'b0;
        end
        if (src_valid && src_ready) begin
            st_hs++;
            if (st_beats == 0) st_hs_pre++;
        end
        if (b) begin
            sent++; st_beats++; beat_edge = cyc;
        end
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (done) begin st_done++; done_edge = cyc; end
        if (err && !st_err_seen) begin st_err_seen = 1; err_edge = cyc; end
        if (uds_idata_valid) st_idv++;
        if (uds_active) st_active++;
        if (src_ready) st_rdy++;
        cyc++;
        start = 1'b0;
        inject_beat = 1'b0;
    endtask

    task automatic clear_stats();
        st_hs = 0; st_hs_pre = 0; st_beats = 0; st_idv = 0; st_done = 0; st_active = 0; st_rdy = 0;
        done_edge = -1; beat_edge = -1; err_edge = -1; st_err_seen = 0;
        due_q.delete(); nf = 0; sent = 0;
    endtask

    task automatic begin_job(input int rows, input int scale, input int mode);
        clear_stats();
        cfg_rows = ROW_W'(rows); cfg_scale = 2'(scale); cfg_mode = 2'(mode);
        start = 1'b1; src_en = 1'b1; start_edge = cyc;
    endtask

    task automatic run_job(input int rows, input int scale, input int mode, input int bound);
        int n;
        begin_job(rows, scale, mode);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(m_pdone || m_perr) && n < bound);
        if (!(m_pdone || m_perr)) begin
            n_checks++;
            $display("FAIL job_timeout: rows=%0d scale=%0d mode=%0d not finished after %0d cycles",
                     rows, scale, mode, n);
        end
        src_en = 1'b0;
        cycle();
        cycle();
        $display("job rows=%0d scale=%0d mode=%0d rows_taken=%0d beats=%0d done=%0d err_code=%0d",
                 rows, scale, mode, st_hs, st_beats, st_done, err_code);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_rows = '0; cfg_scale = '0; cfg_mode = '0;
        src_valid = 1'b0; src_data = '0; uds_odata_valid = 1'b0;
        src_en = 0; inject_beat = 0; inj_feed = 0; stop_after = -1;
        model_reset();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_active", uds_active, 0);
        chk("reset_src_ready", src_ready, 0);
        chk("reset_err", err, 0);
        chk("reset_idata_lo", uds_idata[63:0], 0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Upsample x2, 3 rows: 3 rows in, 6 beats out, done on the edge that counts beat 6.
        run_job(3, 0, 0, 500);
        chk("up2_idv_pulses", st_idv, 3);
        chk("up2_beats", st_beats, 6);
        chk("up2_done_count", st_done, 1);
        chk("up2_done_latency", done_edge - beat_edge, 0);

        // Downsample x4, 8 rows: 4 rows before the first beat, 2 beats in total.
        run_job(8, 1, 1, 500);
        chk("dn4_rows_before_beat", st_hs_pre, 4);
        chk("dn4_rows_total", st_hs, 8);
        chk("dn4_beats", st_beats, 2);
        chk("dn4_done_count", st_done, 1);

        // Illegal configurations.
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: run_job(0, 0, 0, 8);
                1: run_job(4, 3, 0, 8);
                2: run_job(4, 0, 2, 8);
                default: run_job(6, 1, 1, 8);
            endcase
            chk("illegal_err", err, 1);
            chk("illegal_code", err_code, 1);
            chk("illegal_latency", err_edge - start_edge, 0);
            chk("illegal_src_ready_cycles", st_rdy, 0);
            chk("illegal_active_cycles", st_active, 0);
        end

        // Watchdog: UDS stops after 1 of 2 expected beats.
        stop_after = 1;
        run_job(1, 0, 0, 200);
        stop_after = -1;
        chk("tmo_code", err_code, 2);
        chk("tmo_latency", err_edge - beat_edge, 16);
        chk("tmo_busy", busy, 0);

        // Extra beat while rows are being fed.
        inj_feed = 1;
        run_job(2, 0, 0, 200);
        inj_feed = 0;
        chk("feed_beat_code", err_code, 3);

        // Stray beat with no job, then a legal job clears err.
        clear_stats();
        inject_beat = 1;
        cycle();
        chk("idle_beat_err", err, 1);
        chk("idle_beat_code", err_code, 3);
        chk("idle_beat_busy", busy, 0);
        cycle();
        run_job(2, 1, 0, 500);
        chk("recover_done", st_done, 1);
        chk("recover_err", err, 0);

        // Asynchronous reset in the middle of waiting for output beats.
        begin_job(3, 0, 0);
        for (int n = 0; n < 100 && !m_waiting(); n++) cycle();
        chk("pre_reset_active", uds_active, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_active", uds_active, 0);
        chk("async_src_ready", src_ready, 0);
        chk("async_done", done, 0);
        chk("async_err", err, 0);
        chk("async_idv", uds_idata_valid, 0);
        chk("async_idata_lo", uds_idata[63:0], 0);
        chk("async_scale", uds_scale_factor, 0);
        model_reset();
        due_q.delete();
        src_en = 0; src_valid = 1'b0; start = 1'b0; uds_odata_valid = 1'b0;
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;
        cycle();
        run_job(1, 2, 0, 500);
        chk("post_reset_beats", st_beats, 8);
        chk("post_reset_done", st_done, 1);

        // Random legal jobs.
        for (int j = 0; j < 12; j++) begin
            int sc, md, rw;
            sc = $urandom_range(0, 2);
            md = $urandom_range(0, 1);
            rw = (md == 0) ? $urandom_range(1, 5) : (1 << (sc + 1)) * $urandom_range(1, 3);
            run_job(rw, sc, md, 3000);
            chk("rand_done", st_done, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
